// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - host-side word handshake (data/valid/ready) for uart_tx
interface uart_tx_if #(
    parameter int W = 8
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with internal bit divider; optional parity via UART_TX_PARITY_EN
module uart_tx #(
    parameter int DIV  = 434,
    parameter int W    = 8,
    parameter int STOP = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit ODD  = 1'b0
`endif
) (
    input  logic     clock,
    input  logic     reset,
    uart_tx_if.slave bus,
    output logic     txd
);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(W + 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_PRE   = DW'(DIV - 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [W-1:0]  sh_q, sh_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          txd_q, txd_d;
    logic          ready_q, ready_d;
    logic          accept;
    logic          div_end;
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    // Next-state: frame sequencing, bit-period divider, shift register and registered outputs
    always_comb begin
        state_d = state_q;
        div_d   = div_q + DW'(1);
        sh_d    = sh_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        ready_d = ready_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        accept  = bus.valid & ready_q;
        div_end = (div_q == DIV_LAST);

        case (state_q)
            S_IDLE: begin
                div_d   = '0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
            S_START: begin
                if (div_end) begin
                    state_d = S_DATA;
                    div_d   = '0;
                    txd_d   = sh_q[0];
                    sh_d    = sh_q >> 1;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (div_end) begin
                    div_d = '0;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = par_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
                        bit_d   = '0;
`endif
                    end else begin
                        txd_d = sh_q[0];
                        sh_d  = sh_q >> 1;
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (div_end) begin
                    state_d = S_STOP;
                    div_d   = '0;
                    txd_d   = 1'b1;
                    bit_d   = '0;
                end
            end
`endif
            S_STOP: begin
                // Open the handshake one cycle early so a new word can start with no idle gap
                if (bit_q == STOP_LAST && div_q == DIV_PRE) begin
                    ready_d = 1'b1;
                end
                if (div_end) begin
                    div_d = '0;
                    if (bit_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        txd_d   = 1'b1;
                        ready_d = 1'b1;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                txd_d   = 1'b1;
                ready_d = 1'b1;
            end
        endcase

        // Acceptance overrides IDLE and the final stop cycle alike
        if (accept) begin
            state_d = S_START;
            div_d   = '0;
            sh_d    = bus.data;
            bit_d   = '0;
            txd_d   = 1'b0;
            ready_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = (^bus.data) ^ ODD;
`endif
        end
    end

    // State register with synchronous active-high reset; reset aborts any frame in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sh_q    <= sh_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            ready_q <= ready_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd       = txd_q;
    assign bus.ready = ready_q;
endmodule
